// File: rtl/rng_ram.sv
// 512x32 dual-port RAM with two pipelined Wishbone slave ports and an internal
// write path that commits xorshift32 words to an addressed location on request.
module rng_ram (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pA_wb_cyc_i,
    input  logic        pA_wb_stb_i,
    input  logic [3:0]  pA_wb_we_i,
    input  logic [8:0]  pA_wb_addr_i,
    input  logic [31:0] pA_wb_data_i,
    output logic        pA_wb_ack_o,
    output logic        pA_wb_stall_o,
    output logic [31:0] pA_wb_data_o,
    input  logic        pB_wb_cyc_i,
    input  logic        pB_wb_stb_i,
    input  logic [3:0]  pB_wb_we_i,
    input  logic [8:0]  pB_wb_addr_i,
    input  logic [31:0] pB_wb_data_i,
    output logic        pB_wb_ack_o,
    output logic        pB_wb_stall_o,
    output logic [31:0] pB_wb_data_o,
    input  logic        we_rng,
    input  logic [8:0]  addr_rng,
    output logic        ack_rng
);

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t      state, state_next;
    logic [31:0] mem [512];
    logic [31:0] rng_state;
    logic [31:0] rng_word;
    logic [8:0]  rng_addr;
    logic        commit;
    logic        acc_a;
    logic        acc_b;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    assign commit        = (state == COMMIT);
    assign rng_word      = xorshift32(rng_state);
    // The RNG commit borrows port A's write path, so port A stalls for that cycle.
    assign pA_wb_stall_o = commit;
    assign pB_wb_stall_o = 1'b0;
    assign acc_a         = pA_wb_cyc_i & pA_wb_stb_i & ~commit;
    assign acc_b         = pB_wb_cyc_i & pB_wb_stb_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (we_rng) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rng_state <= 32'h0000_0001;
            ack_rng   <= 1'b0;
        end else if (state == IDLE && we_rng) begin
            rng_addr  <= addr_rng;
            ack_rng   <= 1'b0;
        end else if (commit) begin
            rng_state <= rng_word;
            ack_rng   <= 1'b1;
        end
    end

    // Later assignments win: port B, then port A, then the RNG commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_b && pB_wb_we_i[i]) mem[pB_wb_addr_i][8*i +: 8] <= pB_wb_data_i[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (acc_a && pA_wb_we_i[i]) mem[pA_wb_addr_i][8*i +: 8] <= pA_wb_data_i[8*i +: 8];
            end
            if (commit) mem[rng_addr] <= rng_word;
        end
    end

    // Reads are read-first against bus writes; a port B read that coincides
    // with the RNG commit to the same word already sees the new random word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pA_wb_ack_o  <= 1'b0;
            pA_wb_data_o <= '0;
            pB_wb_ack_o  <= 1'b0;
            pB_wb_data_o <= '0;
        end else begin
            pA_wb_ack_o <= acc_a;
            pB_wb_ack_o <= acc_b;
            if (acc_a && pA_wb_we_i == 4'b0000) pA_wb_data_o <= mem[pA_wb_addr_i];
            if (acc_b && pB_wb_we_i == 4'b0000) begin
                if (commit && pB_wb_addr_i == rng_addr) pB_wb_data_o <= rng_word;
                else                                    pB_wb_data_o <= mem[pB_wb_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_rng_ram.sv
// Bench for rng_ram: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_rng_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cyc, a_stb, b_cyc, b_stb;
    logic [3:0]  a_we, b_we;
    logic [8:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic        a_ack, a_stall, b_ack, b_stall;
    logic [31:0] a_dout, b_dout;
    logic        we_rng;
    logic [8:0]  addr_rng;
    logic        ack_rng;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rng_ram dut (
        .clk_i(clk), .rst_i(rst),
        .pA_wb_cyc_i(a_cyc), .pA_wb_stb_i(a_stb), .pA_wb_we_i(a_we),
        .pA_wb_addr_i(a_addr), .pA_wb_data_i(a_din),
        .pA_wb_ack_o(a_ack), .pA_wb_stall_o(a_stall), .pA_wb_data_o(a_dout),
        .pB_wb_cyc_i(b_cyc), .pB_wb_stb_i(b_stb), .pB_wb_we_i(b_we),
        .pB_wb_addr_i(b_addr), .pB_wb_data_i(b_din),
        .pB_wb_ack_o(b_ack), .pB_wb_stall_o(b_stall), .pB_wb_data_o(b_dout),
        .we_rng(we_rng), .addr_rng(addr_rng), .ack_rng(ack_rng)
    );

    function automatic logic [31:0] xs(input logic [31:0] v);
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [31:0] xs_n(input int n);
        logic [31:0] v;
        v = 32'h1;
        for (int k = 0; k < n; k++) v = xs(v);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word array plus a "random word pending" flag.
    logic [31:0] m_mem [512];
    bit          m_known [512];
    logic [31:0] m_x;
    bit          m_pending;
    logic [8:0]  m_paddr;
    logic        e_ack_a, e_ack_b, e_stall_a, e_ack_rng;
    logic [31:0] e_da, e_db;
    bit          e_da_known, e_db_known;

    always @(posedge clk) begin
        logic [31:0] nx, ra, rb;
        bit          ka, kb, acc_a, acc_b;
        if (rst) begin
            m_x = 32'h1; m_pending = 0;
            e_ack_a = 0; e_ack_b = 0; e_stall_a = 0; e_ack_rng = 0;
            e_da = 0; e_db = 0; e_da_known = 1; e_db_known = 1;
        end else begin
            acc_a = a_cyc && a_stb && !m_pending;
            acc_b = b_cyc && b_stb;
            nx = xs(m_x);
            ra = m_mem[a_addr]; ka = m_known[a_addr];
            rb = m_mem[b_addr]; kb = m_known[b_addr];
            if (m_pending && b_addr == m_paddr) begin rb = nx; kb = 1; end
            if (acc_b && b_we != 0) begin
                for (int i = 0; i < 4; i++)
                    if (b_we[i]) m_mem[b_addr][8*i +: 8] = b_din[8*i +: 8];
                m_known[b_addr] = m_known[b_addr] || (b_we == 4'hF);
            end
            if (acc_a && a_we != 0) begin
                for (int i = 0; i < 4; i++)
                    if (a_we[i]) m_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
                m_known[a_addr] = m_known[a_addr] || (a_we == 4'hF);
            end
            if (m_pending) begin
                m_mem[m_paddr] = nx; m_known[m_paddr] = 1;
                m_x = nx; e_ack_rng = 1; m_pending = 0;
            end else if (we_rng) begin
                m_pending = 1; m_paddr = addr_rng; e_ack_rng = 0;
            end
            e_ack_a = acc_a;
            e_ack_b = acc_b;
            if (acc_a && a_we == 0) begin e_da = ra; e_da_known = ka; end
            if (acc_b && b_we == 0) begin e_db = rb; e_db_known = kb; end
            e_stall_a = m_pending;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ack_a", a_ack, e_ack_a);
            check("m_ack_b", b_ack, e_ack_b);
            check("m_stall_a", a_stall, e_stall_a);
            check("m_stall_b", b_stall, 0);
            check("m_ack_rng", ack_rng, e_ack_rng);
            if (e_da_known) check("m_data_a", a_dout, e_da);
            if (e_db_known) check("m_data_b", b_dout, e_db);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic b_read(input logic [8:0] ad, output logic [31:0] v);
        b_cyc = 1; b_stb = 1; b_we = 0; b_addr = ad;
        step();
        check("b_read_ack", b_ack, 1);
        v = b_dout;
        b_cyc = 0; b_stb = 0;
    endtask

    task automatic a_write(input logic [8:0] ad, input logic [31:0] d, input logic [3:0] we);
        a_cyc = 1; a_stb = 1; a_we = we; a_addr = ad; a_din = d;
        check("a_stall_idle", a_stall, 0);
        step();
        check("a_write_ack", a_ack, 1);
        a_cyc = 0; a_stb = 0; a_we = 0;
    endtask

    task automatic rng_write(input logic [8:0] ad);
        we_rng = 1; addr_rng = ad;
        step();
        we_rng = 0;
        step();
    endtask

    initial begin
        logic [31:0] v, held;
        logic [31:0] rec [8];
        int n;
        for (int i = 0; i < 512; i++) m_known[i] = 0;
        rst = 1; a_cyc = 0; a_stb = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = 0; b_din = 0;
        we_rng = 0; addr_rng = 0;
        step();
        chk_en = 1;
        step();
        check("rst_ack_rng", ack_rng, 0);
        check("rst_ack_a", a_ack, 0);
        check("rst_ack_b", b_ack, 0);
        check("rst_data_a", a_dout, 0);
        check("rst_data_b", b_dout, 0);
        check("rst_stall_a", a_stall, 0);
        rst = 0;
        step();

        // first random word
        we_rng = 1; addr_rng = 0;
        step();
        we_rng = 0;
        check("commit_stall", a_stall, 1);
        check("ack_rng_cleared", ack_rng, 0);
        step();
        check("ack_rng_rise", ack_rng, 1);
        b_read(0, v);
        check("rng_word0", v, 32'h00042021);

        rng_write(1);
        b_read(1, v);
        check("rng_word1", v, 32'h04080601);
        check("ack_rng_held", ack_rng, 1);

        for (int i = 0; i < 8; i++) begin
            rng_write(i[8:0]);
            b_read(i[8:0], rec[i]);
        end
        for (int i = 0; i < 8; i++) begin
            b_read(i[8:0], v);
            check("reread", v, rec[i]);
        end

        // byte-lane write
        a_write(5, 32'h11223344, 4'hF);
        a_write(5, 32'hDEADBEEF, 4'b0011);
        b_read(5, v);
        check("byte_lanes", v, 32'h1122BEEF);

        // port A request during COMMIT
        we_rng = 1; addr_rng = 10;
        step();
        we_rng = 0;
        a_cyc = 1; a_stb = 1; a_we = 4'hF; a_addr = 11; a_din = 32'hCAFEF00D;
        check("stall_in_commit", a_stall, 1);
        step();
        check("ack_while_stalled", a_ack, 0);
        check("stall_released", a_stall, 0);
        step();
        check("ack_after_stall", a_ack, 1);
        a_cyc = 0; a_stb = 0; a_we = 0;
        b_read(10, v);
        check("rng_word_11th", v, xs_n(11));
        b_read(11, v);
        check("a_write_intact", v, 32'hCAFEF00D);

        // held strobe on port B
        b_cyc = 1; b_stb = 1; b_we = 0; b_addr = 2;
        n = 0;
        repeat (3) begin
            step();
            if (b_ack) n++;
        end
        b_cyc = 0; b_stb = 0;
        held = b_dout;
        check("three_acks", n, 3);
        check("held_value", held, rec[2]);
        step();
        check("ack_drops", b_ack, 0);
        check("data_hold1", b_dout, held);
        step();
        check("data_hold2", b_dout, held);

        // reset during COMMIT
        a_write(20, 32'h55AA55AA, 4'hF);
        we_rng = 1; addr_rng = 20;
        step();
        we_rng = 0; rst = 1;
        step();
        rst = 0;
        check("rst_mid_ack_rng", ack_rng, 0);
        check("rst_mid_stall", a_stall, 0);
        rng_write(21);
        b_read(21, v);
        check("rng_after_rst", v, 32'h00042021);
        b_read(20, v);
        check("no_write_on_rst", v, 32'h55AA55AA);

        // randomized traffic on a small address window to provoke collisions
        for (int i = 0; i < 16; i++) a_write(i[8:0], $urandom, 4'hF);
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            a_cyc    = ($urandom_range(0, 3) != 0);
            a_stb    = $urandom_range(0, 1);
            a_we     = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
            a_addr   = 9'($urandom_range(0, 15));
            a_din    = $urandom;
            b_cyc    = ($urandom_range(0, 3) != 0);
            b_stb    = $urandom_range(0, 1);
            b_we     = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
            b_addr   = 9'($urandom_range(0, 15));
            b_din    = $urandom;
            we_rng   = ($urandom_range(0, 4) == 0);
            addr_rng = 9'($urandom_range(0, 15));
            step();
        end
        rst = 0; a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0; we_rng = 0;
        step();
        step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
